// File: rtl/id_stage_ctrl_if.sv
// Fetch-to-decode and decode-to-execute signal bundle for the RV32I decode-stage controller.
// Handshake: a beat moves on a rising clk edge where valid and ready are both high; valid never waits on ready.
interface id_stage_ctrl_if #(
   parameter int XLEN = 32,
   parameter int ILEN = 32
);
   logic            if_valid;
   logic            if_ready;
   logic [ILEN-1:0] if_inst;
   logic [XLEN-1:0] if_pc;
   logic            ex_ready;
   logic            ex_is_load;
   logic [4:0]      ex_rd;
   logic            flush;
   logic            id_valid;
   logic [ILEN-1:0] id_inst;
   logic [XLEN-1:0] id_pc;
   logic [2:0]      imm_type;
   logic            imm_used;
   logic            illegal_inst;
   logic            hazard_stall;
   logic [1:0]      dbg_state;

   modport master (
      output if_valid, if_inst, if_pc, ex_ready, ex_is_load, ex_rd, flush,
      input  if_ready, id_valid, id_inst, id_pc, imm_type, imm_used, illegal_inst,
             hazard_stall, dbg_state
   );

   modport slave (
      input  if_valid, if_inst, if_pc, ex_ready, ex_is_load, ex_rd, flush,
      output if_ready, id_valid, id_inst, id_pc, imm_type, imm_used, illegal_inst,
             hazard_stall, dbg_state
   );
endinterface

// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: 2-entry skid buffer for fetched beats, opcode-to-immediate-type
// classification, load-use bubble insertion and flush handling.
module id_stage_ctrl #(
   parameter int XLEN = 32,
   parameter int ILEN = 32
) (
   input logic           clk,
   input logic           rst,
   id_stage_ctrl_if.slave bus
);
   localparam logic [2:0] RTYPE = 3'd0;
   localparam logic [2:0] ITYPE = 3'd1;
   localparam logic [2:0] STYPE = 3'd2;
   localparam logic [2:0] BTYPE = 3'd3;
   localparam logic [2:0] UTYPE = 3'd4;
   localparam logic [2:0] JTYPE = 3'd5;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] SYSTEM = 7'b1110011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] OP     = 7'b0110011;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            if_ready_q;
   logic [ILEN-1:0] main_inst;
   logic [XLEN-1:0] main_pc;
   logic [ILEN-1:0] skid_inst;
   logic [XLEN-1:0] skid_pc;

   logic            main_full;
   logic            accept;
   logic            issue;
   logic            hazard;
   logic            id_valid;
   logic            ld_main_if;
   logic            ld_main_skid;
   logic            ld_skid;

   logic [6:0]      opcode;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic            rs1_used;
   logic            rs2_used;
   logic [2:0]      imm_type;
   logic            imm_used;
   logic            illegal;

   assign opcode    = main_inst[6:0];
   assign rs1       = main_inst[19:15];
   assign rs2       = main_inst[24:20];
   assign main_full = (state != EMPTY);

   // Classification only reflects a held instruction; an empty main entry reads as a benign I-type.
   always_comb begin
      imm_type = ITYPE;
      imm_used = 1'b0;
      illegal  = 1'b0;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      if (main_full) begin
         case (opcode)
            OP_IMM, LOAD, JALR, SYSTEM: begin
               imm_used = 1'b1;
               rs1_used = 1'b1;
            end
            STORE: begin
               imm_type = STYPE;
               imm_used = 1'b1;
               rs1_used = 1'b1;
               rs2_used = 1'b1;
            end
            BRANCH: begin
               imm_type = BTYPE;
               imm_used = 1'b1;
               rs1_used = 1'b1;
               rs2_used = 1'b1;
            end
            LUI, AUIPC: begin
               imm_type = UTYPE;
               imm_used = 1'b1;
            end
            JAL: begin
               imm_type = JTYPE;
               imm_used = 1'b1;
            end
            OP: begin
               rs1_used = 1'b1;
               rs2_used = 1'b1;
            end
            default: begin
               illegal  = 1'b1;
               rs1_used = 1'b1;
            end
         endcase
      end
   end

   // x0 never carries a real load result, so it cannot cause a load-use bubble.
   assign hazard = main_full & bus.ex_is_load & (bus.ex_rd != 5'd0) &
                   ((rs1_used & (bus.ex_rd == rs1)) | (rs2_used & (bus.ex_rd == rs2)));

   assign id_valid = main_full & ~hazard;
   assign accept   = bus.if_valid & if_ready_q;
   assign issue    = id_valid & bus.ex_ready;

   always_comb begin
      state_nxt    = state;
      ld_main_if   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      if (bus.flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state_nxt  = ONE;
                  ld_main_if = 1'b1;
               end
            end
            ONE: begin
               if (accept && issue) begin
                  ld_main_if = 1'b1;
               end else if (accept) begin
                  state_nxt = TWO;
                  ld_skid   = 1'b1;
               end else if (issue) begin
                  state_nxt = EMPTY;
               end
            end
            TWO: begin
               if (issue) begin
                  state_nxt    = ONE;
                  ld_main_skid = 1'b1;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // Ready is registered from the next state so fetch sees a clean, glitch-free ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= EMPTY;
         if_ready_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         if_ready_q <= (state_nxt != TWO);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_inst <= '0;
         main_pc   <= '0;
         skid_inst <= '0;
         skid_pc   <= '0;
      end else begin
         if (ld_main_if) begin
            main_inst <= bus.if_inst;
            main_pc   <= bus.if_pc;
         end else if (ld_main_skid) begin
            main_inst <= skid_inst;
            main_pc   <= skid_pc;
         end
         if (ld_skid) begin
            skid_inst <= bus.if_inst;
            skid_pc   <= bus.if_pc;
         end
      end
   end

   assign bus.if_ready     = if_ready_q;
   assign bus.id_valid     = id_valid;
   assign bus.id_inst      = main_inst;
   assign bus.id_pc        = main_pc;
   assign bus.imm_type     = imm_type;
   assign bus.imm_used     = imm_used;
   assign bus.illegal_inst = illegal;
   assign bus.hazard_stall = hazard;
   assign bus.dbg_state    = state;
endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed bench for id_stage_ctrl: handshake/skid ordering, opcode classification,
// load-use bubbles, flush and asynchronous reset, with an in-order issue scoreboard.
module tb_id_stage_ctrl;
   localparam logic [2:0] ITYPE = 3'd1;
   localparam logic [2:0] STYPE = 3'd2;
   localparam logic [2:0] BTYPE = 3'd3;
   localparam logic [2:0] UTYPE = 3'd4;
   localparam logic [2:0] JTYPE = 3'd5;
   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_TWO   = 2'd2;

   localparam logic [31:0] I_ADDI = 32'h00500093;
   localparam logic [31:0] I_SW   = 32'h00112223;
   localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
   localparam logic [31:0] I_X0   = 32'h00A00113;
   localparam logic [31:0] I_X1   = 32'h00000297;
   localparam logic [31:0] I_X2   = 32'h0000006F;
   localparam logic [31:0] I_ADD  = 32'h00528333;
   localparam logic [31:0] I_LUI  = 32'h123450B7;
   localparam logic [31:0] I_ILL  = 32'h0000007F;
   localparam logic [31:0] I_NOP  = 32'h00000013;
   localparam logic [31:0] I_F1   = 32'h00100093;
   localparam logic [31:0] I_F2   = 32'h00200093;
   localparam logic [31:0] I_F3   = 32'h00300093;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   logic [31:0] exp_q[$];

   id_stage_ctrl_if bus ();

   id_stage_ctrl dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic beat(input logic [31:0] inst, input logic [31:0] pc);
      bus.if_valid = 1'b1;
      bus.if_inst  = inst;
      bus.if_pc    = pc;
   endtask

   // scoreboard: every issued beat must be the next expected one
   always @(negedge clk) begin
      logic [31:0] e;
      if (!rst && bus.id_valid && bus.ex_ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_issue", bus.id_inst, 32'h0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_issue_order", bus.id_inst, e);
         end
      end
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      rst            = 1'b1;
      bus.if_valid   = 1'b0;
      bus.if_inst    = '0;
      bus.if_pc      = '0;
      bus.ex_ready   = 1'b0;
      bus.ex_is_load = 1'b0;
      bus.ex_rd      = 5'd0;
      bus.flush      = 1'b0;

      // reset values
      tick();
      tick();
      chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
      chk("rst_if_ready", 32'(bus.if_ready), 32'd0);
      chk("rst_hazard", 32'(bus.hazard_stall), 32'd0);
      chk("rst_id_inst", bus.id_inst, 32'd0);
      chk("rst_id_pc", bus.id_pc, 32'd0);
      rst = 1'b0;
      mid();
      chk("rst_rel_ready_low", 32'(bus.if_ready), 32'd0);
      tick();
      mid();
      chk("rst_rel_ready_high", 32'(bus.if_ready), 32'd1);

      // 1: back-to-back stream, one beat per cycle
      begin
         logic [31:0] insts [3];
         logic [2:0]  types [3];
         insts[0] = I_ADDI; insts[1] = I_SW;  insts[2] = I_BEQ;
         types[0] = ITYPE;  types[1] = STYPE; types[2] = BTYPE;
         for (int i = 0; i < 3; i++) exp_q.push_back(insts[i]);
         tick();
         bus.ex_ready = 1'b1;
         beat(insts[0], 32'h1000);
         for (int i = 0; i < 3; i++) begin
            tick();
            if (i < 2) beat(insts[i+1], 32'h1000 + 32'(4 * (i + 1)));
            else bus.if_valid = 1'b0;
            mid();
            chk("t1_id_valid", 32'(bus.id_valid), 32'd1);
            chk("t1_id_inst", bus.id_inst, insts[i]);
            chk("t1_id_pc", bus.id_pc, 32'h1000 + 32'(4 * i));
            chk("t1_imm_type", 32'(bus.imm_type), 32'(types[i]));
            chk("t1_imm_used", 32'(bus.imm_used), 32'd1);
            chk("t1_hazard", 32'(bus.hazard_stall), 32'd0);
         end
         tick();
         mid();
         chk("t1_drained", 32'(bus.id_valid), 32'd0);
      end

      // 2: EX back-pressure fills the skid entry, then drains in order
      exp_q.push_back(I_X0);
      exp_q.push_back(I_X1);
      exp_q.push_back(I_X2);
      bus.ex_ready = 1'b0;
      beat(I_X0, 32'h2000);
      tick();
      beat(I_X1, 32'h2004);
      mid();
      chk("t2_state_one", 32'(bus.dbg_state), 32'(S_ONE));
      chk("t2_ready_one", 32'(bus.if_ready), 32'd1);
      tick();
      beat(I_X2, 32'h2008);
      mid();
      chk("t2_state_two", 32'(bus.dbg_state), 32'(S_TWO));
      chk("t2_ready_two", 32'(bus.if_ready), 32'd0);
      chk("t2_main_held", bus.id_inst, I_X0);
      tick();
      bus.ex_ready = 1'b1;
      mid();
      chk("t2_still_two", 32'(bus.dbg_state), 32'(S_TWO));
      chk("t2_still_not_ready", 32'(bus.if_ready), 32'd0);
      tick();
      mid();
      chk("t2_skid_to_main", bus.id_inst, I_X1);
      chk("t2_ready_back", 32'(bus.if_ready), 32'd1);
      chk("t2_utype", 32'(bus.imm_type), 32'(UTYPE));
      tick();
      bus.if_valid = 1'b0;
      mid();
      chk("t2_third_beat", bus.id_inst, I_X2);
      chk("t2_jtype", 32'(bus.imm_type), 32'(JTYPE));
      tick();
      mid();
      chk("t2_empty", 32'(bus.dbg_state), 32'(S_EMPTY));

      // 3: load-use bubbles on rs1/rs2, none when the load targets x0
      exp_q.push_back(I_ADD);
      exp_q.push_back(I_ADD);
      exp_q.push_back(I_SW);
      beat(I_ADD, 32'h3000);
      bus.ex_is_load = 1'b1;
      bus.ex_rd      = 5'd5;
      tick();
      bus.if_valid = 1'b0;
      mid();
      chk("t3_stall", 32'(bus.hazard_stall), 32'd1);
      chk("t3_stall_no_valid", 32'(bus.id_valid), 32'd0);
      chk("t3_rtype_no_imm", 32'(bus.imm_used), 32'd0);
      tick();
      bus.ex_is_load = 1'b0;
      mid();
      chk("t3_stall_clear", 32'(bus.hazard_stall), 32'd0);
      chk("t3_valid_again", 32'(bus.id_valid), 32'd1);
      chk("t3_same_inst", bus.id_inst, I_ADD);
      tick();
      beat(I_ADD, 32'h3004);
      bus.ex_is_load = 1'b1;
      bus.ex_rd      = 5'd0;
      tick();
      bus.if_valid = 1'b0;
      mid();
      chk("t3_x0_no_stall", 32'(bus.hazard_stall), 32'd0);
      chk("t3_x0_valid", 32'(bus.id_valid), 32'd1);
      tick();
      beat(I_SW, 32'h3008);
      bus.ex_rd = 5'd1;
      tick();
      bus.if_valid = 1'b0;
      mid();
      chk("t3_rs2_stall", 32'(bus.hazard_stall), 32'd1);
      tick();
      bus.ex_is_load = 1'b0;
      mid();
      chk("t3_rs2_clear", 32'(bus.id_valid), 32'd1);
      tick();

      // 4: lui uses no source register, so no bubble whatever rd the load has
      exp_q.push_back(I_LUI);
      beat(I_LUI, 32'h4000);
      bus.ex_ready   = 1'b0;
      bus.ex_is_load = 1'b1;
      bus.ex_rd      = 5'd8;
      tick();
      bus.if_valid = 1'b0;
      mid();
      chk("t4_rs1field_no_stall", 32'(bus.hazard_stall), 32'd0);
      chk("t4_valid", 32'(bus.id_valid), 32'd1);
      chk("t4_utype", 32'(bus.imm_type), 32'(UTYPE));
      chk("t4_imm_used", 32'(bus.imm_used), 32'd1);
      tick();
      bus.ex_rd = 5'd0;
      mid();
      chk("t4_x0_no_stall", 32'(bus.hazard_stall), 32'd0);
      tick();
      bus.ex_ready   = 1'b1;
      bus.ex_is_load = 1'b0;
      tick();

      // 5: flush from TWO kills both held beats; issue in the flush cycle still counts
      exp_q.push_back(I_NOP);
      bus.ex_ready = 1'b0;
      beat(I_NOP, 32'h5000);
      tick();
      beat(I_F1, 32'h5004);
      tick();
      beat(I_F2, 32'h5008);
      bus.flush    = 1'b1;
      bus.ex_ready = 1'b1;
      mid();
      chk("t5_pre_flush_two", 32'(bus.dbg_state), 32'(S_TWO));
      tick();
      bus.flush    = 1'b0;
      bus.if_valid = 1'b0;
      mid();
      chk("t5_flush_no_valid", 32'(bus.id_valid), 32'd0);
      chk("t5_flush_ready", 32'(bus.if_ready), 32'd1);
      chk("t5_flush_empty", 32'(bus.dbg_state), 32'(S_EMPTY));
      tick();
      beat(I_F3, 32'h500C);
      bus.flush = 1'b1;
      tick();
      bus.flush    = 1'b0;
      bus.if_valid = 1'b0;
      mid();
      chk("t5_flush_drops_accept", 32'(bus.id_valid), 32'd0);
      chk("t5_flush_ready2", 32'(bus.if_ready), 32'd1);
      tick();
      exp_q.push_back(I_ADDI);
      beat(I_ADDI, 32'h5010);
      tick();
      bus.if_valid = 1'b0;
      mid();
      chk("t5_recover_inst", bus.id_inst, I_ADDI);
      chk("t5_recover_pc", bus.id_pc, 32'h5010);
      tick();

      // 6: illegal opcode, then reset in the middle of a full buffer
      exp_q.push_back(I_ILL);
      bus.ex_ready = 1'b0;
      beat(I_ILL, 32'h6000);
      tick();
      bus.if_valid = 1'b0;
      mid();
      chk("t6_illegal", 32'(bus.illegal_inst), 32'd1);
      chk("t6_illegal_no_imm", 32'(bus.imm_used), 32'd0);
      chk("t6_illegal_itype", 32'(bus.imm_type), 32'(ITYPE));
      chk("t6_illegal_valid", 32'(bus.id_valid), 32'd1);
      tick();
      bus.ex_ready = 1'b1;
      tick();
      bus.ex_ready = 1'b0;
      beat(I_F1, 32'h6004);
      tick();
      beat(I_F2, 32'h6008);
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_state", 32'(bus.dbg_state), 32'(S_EMPTY));
      chk("t6_rst_id_valid", 32'(bus.id_valid), 32'd0);
      chk("t6_rst_if_ready", 32'(bus.if_ready), 32'd0);
      chk("t6_rst_hazard", 32'(bus.hazard_stall), 32'd0);
      chk("t6_rst_id_inst", bus.id_inst, 32'd0);
      chk("t6_rst_id_pc", bus.id_pc, 32'd0);
      chk("t6_rst_illegal", 32'(bus.illegal_inst), 32'd0);
      bus.if_valid = 1'b0;
      tick();
      rst = 1'b0;
      mid();
      chk("t6_rel_ready_low", 32'(bus.if_ready), 32'd0);
      tick();
      mid();
      chk("t6_rel_ready_high", 32'(bus.if_ready), 32'd1);
      chk("t6_rel_no_valid", 32'(bus.id_valid), 32'd0);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
